// File: rtl/alu_pkg.sv
// Shared constants for the ALU control path: ALUCntl encodings, MIPS opcode/funct
// values and the decoder result bundle.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b1010;
   localparam logic [3:0] ALU_ADDU = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b1110;
   localparam logic [3:0] ALU_SUBU = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_SLT  = 4'b1101;
   localparam logic [3:0] ALU_SLTU = 4'b1111;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef struct packed {
      logic [3:0] alu_cntl;
      logic       reg_write;
      logic       reg_dst;
      logic       imm_sel;
      logic       sign_ext;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// Upstream/downstream handshake and payload bundle of the ALU control stage.
// master = the side feeding instructions and consuming results; slave = the stage.
interface alu_ctrl_stage_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        ALUCntl;
   logic              RegWrite;
   logic              RegDst;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              illegal;
   logic [CNT_W-1:0]  illegal_cnt;

   modport master (
      output in_valid, instr, rs_data, rt_data, flush, out_ready,
      input  in_ready, out_valid, ALUCntl, RegWrite, RegDst, op_a, op_b, illegal, illegal_cnt
   );

   modport slave (
      input  in_valid, instr, rs_data, rt_data, flush, out_ready,
      output in_ready, out_valid, ALUCntl, RegWrite, RegDst, op_a, op_b, illegal, illegal_cnt
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of an R-type / I-type MIPS ALU instruction into control fields.
// Anything unrecognised comes out as illegal with every control field forced to zero.
module alu_ctrl_decode
   import alu_pkg::*;
#(
   parameter int LEGACY = 0
) (
   input  logic [31:0] instr,
   output dec_t        dec
);

   logic [5:0] op;
   logic [5:0] fn;

   assign op = instr[31:26];
   assign fn = instr[5:0];

   always_comb begin
      dec         = '0;
      dec.illegal = 1'b1;
      if (op == OP_RTYPE) begin
         dec.reg_write = 1'b1;
         dec.reg_dst   = 1'b1;
         dec.illegal   = 1'b0;
         case (fn)
            FN_ADD:  dec.alu_cntl = ALU_ADD;
            FN_ADDU: dec.alu_cntl = ALU_ADDU;
            FN_SUB:  dec.alu_cntl = ALU_SUB;
            FN_SUBU: dec.alu_cntl = ALU_SUBU;
            FN_AND:  dec.alu_cntl = ALU_AND;
            FN_OR:   dec.alu_cntl = ALU_OR;
            FN_XOR:  dec.alu_cntl = ALU_XOR;
            FN_NOR:  dec.alu_cntl = ALU_NOR;
            FN_SLT:  dec.alu_cntl = ALU_SLT;
            FN_SLTU: dec.alu_cntl = ALU_SLTU;
            default: begin
               dec.reg_write = 1'b0;
               dec.reg_dst   = 1'b0;
               dec.illegal   = 1'b1;
            end
         endcase
      end else if (LEGACY == 0) begin
         // arithmetic/compare immediates sign-extend, logical ones zero-extend
         dec.reg_write = 1'b1;
         dec.imm_sel   = 1'b1;
         dec.illegal   = 1'b0;
         case (op)
            OP_ADDI:  begin dec.alu_cntl = ALU_ADD;  dec.sign_ext = 1'b1; end
            OP_ADDIU: begin dec.alu_cntl = ALU_ADDU; dec.sign_ext = 1'b1; end
            OP_SLTI:  begin dec.alu_cntl = ALU_SLT;  dec.sign_ext = 1'b1; end
            OP_SLTIU: begin dec.alu_cntl = ALU_SLTU; dec.sign_ext = 1'b1; end
            OP_ANDI:  dec.alu_cntl = ALU_AND;
            OP_ORI:   dec.alu_cntl = ALU_OR;
            OP_XORI:  dec.alu_cntl = ALU_XOR;
            default: begin
               dec.reg_write = 1'b0;
               dec.imm_sel   = 1'b0;
               dec.illegal   = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered decode/control stage between register-file read and the ALU: one-entry
// valid/ready pipeline register, flush support and a saturating illegal-instruction counter.
module alu_ctrl_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8,
   parameter int LEGACY = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_ctrl_stage_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   dec_t              dec;
   logic              accept;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] op_b_next;

   alu_ctrl_decode #(.LEGACY(LEGACY)) u_decode (
      .instr (bus.instr),
      .dec   (dec)
   );

   assign bus.in_ready = !bus.out_valid | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;

   assign imm_ext   = dec.sign_ext ? DATA_W'(signed'(bus.instr[15:0])) : DATA_W'(bus.instr[15:0]);
   assign op_b_next = dec.imm_sel ? imm_ext : bus.rt_data;

   // flush wins over a same-cycle accept; a consume without a refill empties the stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ALUCntl  <= '0;
         bus.RegWrite <= 1'b0;
         bus.RegDst   <= 1'b0;
         bus.illegal  <= 1'b0;
         bus.op_a     <= '0;
         bus.op_b     <= '0;
      end else if (accept && !bus.flush) begin
         bus.ALUCntl  <= dec.alu_cntl;
         bus.RegWrite <= dec.reg_write;
         bus.RegDst   <= dec.reg_dst;
         bus.illegal  <= dec.illegal;
         bus.op_a     <= bus.rs_data;
         bus.op_b     <= op_b_next;
      end
   end

   // counts every accepted illegal entry, including ones a flush then drops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.illegal_cnt <= '0;
      end else if (accept && dec.illegal && (bus.illegal_cnt != CNT_MAX)) begin
         bus.illegal_cnt <= bus.illegal_cnt + 1'b1;
      end
   end

endmodule
